// File: rtl/matrix_store_writer.sv
// matrix_store_writer
//   Takes the element stream produced by the UART command parser in INPUT mode and writes the
//   elements row-major into fixed-size matrix slots in RAM. Keeps a per-slot descriptor table
//   (valid, m, n) that later stages read combinationally through the query port.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   start_input               1-cycle pulse: parser began an INPUT/GEN command
//   dim_m, dim_n              rows/cols from the parser, stable during a command
//   elem_data, write_en       element value and its 1-cycle strobe
//   data_ready                1-cycle end-of-command pulse
//   mem_we/mem_addr/mem_wdata registered RAM write port
//   commit_valid, commit_id   matrix stored pulse and slot ID (ID held until next commit)
//   err_valid, err_code       command rejected pulse and cause (code held until next error)
//   busy                      high while filling or dropping a command
//   stored_cnt                number of valid slots
//   q_id, q_valid, q_m, q_n   combinational descriptor query
module matrix_store_writer #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned MAX_DIM   = 5,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned ID_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_input,
  input  logic [2:0]        dim_m,
  input  logic [2:0]        dim_n,
  input  logic [DATA_W-1:0] elem_data,
  input  logic              write_en,
  input  logic              data_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              commit_valid,
  output logic [ID_W-1:0]   commit_id,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [2:0]        stored_cnt,
  input  logic [ID_W-1:0]   q_id,
  output logic              q_valid,
  output logic [2:0]        q_m,
  output logic [2:0]        q_n
);

  localparam int unsigned SLOT_SZ = MAX_DIM * MAX_DIM;

  localparam logic [1:0] ErrDims  = 2'b01;
  localparam logic [1:0] ErrOvf   = 2'b10;
  localparam logic [1:0] ErrShort = 2'b11;

  typedef enum logic [1:0] {StIdle, StArmed, StFill, StDrop} state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [4:0]            idx_q, idx_d;
  logic [4:0]            total_q, total_d;
  logic [2:0]            m_lat_q, m_lat_d;
  logic [2:0]            n_lat_q, n_lat_d;
  logic [NUM_SLOTS-1:0]  valid_q, valid_d;
  logic [2:0]            slot_m_q [NUM_SLOTS];
  logic [2:0]            slot_m_d [NUM_SLOTS];
  logic [2:0]            slot_n_q [NUM_SLOTS];
  logic [2:0]            slot_n_d [NUM_SLOTS];

  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  commit_valid_q, commit_valid_d;
  logic [ID_W-1:0]       commit_id_q, commit_id_d;
  logic                  err_valid_q, err_valid_d;
  logic [1:0]            err_code_q, err_code_d;

  // Per-cycle actions decided by the FSM, applied by the datapath block.
  logic                  do_write;
  logic [4:0]            wr_idx;
  logic                  do_commit;
  logic                  do_err;
  logic [1:0]            err_sel;
  logic                  clear_slot;

  logic                  dims_ok;
  logic [ADDR_W-1:0]     slot_base;

  assign dims_ok = (dim_m != 3'd0) && (32'(dim_m) <= MAX_DIM) &&
                   (dim_n != 3'd0) && (32'(dim_n) <= MAX_DIM);

  // Constant multiply; idx never exceeds total-1 < SLOT_SZ, so the address stays in the slot.
  assign slot_base = ADDR_W'(32'(wr_ptr_q) * SLOT_SZ);

  // FSM: next state and per-cycle action flags.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    total_d    = total_q;
    m_lat_d    = m_lat_q;
    n_lat_d    = n_lat_q;
    do_write   = 1'b0;
    wr_idx     = '0;
    do_commit  = 1'b0;
    do_err     = 1'b0;
    err_sel    = 2'b00;
    clear_slot = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_input) state_d = StArmed;
      end

      StArmed: begin
        if (write_en) begin
          if (!dims_ok) begin
            do_err  = 1'b1;
            err_sel = ErrDims;
            state_d = data_ready ? StIdle : StDrop;
          end else begin
            m_lat_d    = dim_m;
            n_lat_d    = dim_n;
            total_d    = 5'(dim_m) * 5'(dim_n);
            // Invalidate before the first write so readers never see a partial matrix.
            clear_slot = 1'b1;
            do_write   = 1'b1;
            wr_idx     = 5'd0;
            idx_d      = 5'd1;
            state_d    = StFill;
            // Element first, then the completeness check.
            if (data_ready) begin
              state_d = StIdle;
              if (total_d == 5'd1) begin
                do_commit = 1'b1;
              end else begin
                do_err  = 1'b1;
                err_sel = ErrShort;
              end
            end
          end
        end else if (data_ready) begin
          // GEN command with no elements: silent return.
          state_d = StIdle;
        end
      end

      StFill: begin
        if (start_input) begin
          do_err  = 1'b1;
          err_sel = ErrShort;
          state_d = StArmed;
        end else begin
          if (write_en) begin
            if (idx_q < total_q) begin
              do_write = 1'b1;
              wr_idx   = idx_q;
              idx_d    = 5'(idx_q + 5'd1);
            end else begin
              do_err  = 1'b1;
              err_sel = ErrOvf;
              state_d = StDrop;
            end
          end
          if (data_ready) begin
            if (state_d == StFill) begin
              if (idx_d == total_q) begin
                do_commit = 1'b1;
              end else begin
                do_err  = 1'b1;
                err_sel = ErrShort;
              end
            end
            state_d = StIdle;
          end
        end
      end

      StDrop: begin
        if (start_input) begin
          state_d = StArmed;
        end else if (data_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Datapath: RAM write port, pulses, descriptor table and slot pointer.
  always_comb begin
    valid_d        = valid_q;
    slot_m_d       = slot_m_q;
    slot_n_d       = slot_n_q;
    wr_ptr_d       = wr_ptr_q;
    mem_we_d       = do_write;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    commit_valid_d = do_commit;
    commit_id_d    = commit_id_q;
    err_valid_d    = do_err;
    err_code_d     = err_code_q;

    if (do_write) begin
      mem_addr_d  = slot_base + ADDR_W'(wr_idx);
      mem_wdata_d = elem_data;
    end

    if (do_err) err_code_d = err_sel;

    if (clear_slot) valid_d[wr_ptr_q] = 1'b0;

    // Applied after the clear so a 1x1 finished in one cycle ends up valid.
    if (do_commit) begin
      valid_d[wr_ptr_q]  = 1'b1;
      slot_m_d[wr_ptr_q] = m_lat_d;
      slot_n_d[wr_ptr_q] = n_lat_d;
      commit_id_d        = wr_ptr_q;
      if (32'(wr_ptr_q) == NUM_SLOTS - 1) begin
        wr_ptr_d = '0;
      end else begin
        wr_ptr_d = ID_W'(wr_ptr_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      idx_q          <= '0;
      total_q        <= '0;
      m_lat_q        <= '0;
      n_lat_q        <= '0;
      valid_q        <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      err_valid_q    <= 1'b0;
      err_code_q     <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slot_m_q[i] <= '0;
        slot_n_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      idx_q          <= idx_d;
      total_q        <= total_d;
      m_lat_q        <= m_lat_d;
      n_lat_q        <= n_lat_d;
      valid_q        <= valid_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
      err_valid_q    <= err_valid_d;
      err_code_q     <= err_code_d;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slot_m_q[i] <= slot_m_d[i];
        slot_n_q[i] <= slot_n_d[i];
      end
    end
  end

  // Count of valid slots; tracks overwrite-clears and commits automatically.
  always_comb begin
    stored_cnt = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      stored_cnt = stored_cnt + 3'(valid_q[i]);
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign commit_valid = commit_valid_q;
  assign commit_id    = commit_id_q;
  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign busy         = (state_q == StFill) || (state_q == StDrop);

  assign q_valid = valid_q[q_id];
  assign q_m     = slot_m_q[q_id];
  assign q_n     = slot_n_q[q_id];

endmodule

// File: tb/tb_matrix_store_writer.sv
// Testbench for matrix_store_writer: directed scenarios plus randomized command streams, all
// checked cycle by cycle against a command-level reference model.
module tb_matrix_store_writer;

  logic       clk;
  logic       rst;
  logic       start_input;
  logic [2:0] dim_m;
  logic [2:0] dim_n;
  logic [7:0] elem_data;
  logic       write_en;
  logic       data_ready;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       commit_valid;
  logic [1:0] commit_id;
  logic       err_valid;
  logic [1:0] err_code;
  logic       busy;
  logic [2:0] stored_cnt;
  logic [1:0] q_id;
  logic       q_valid;
  logic [2:0] q_m;
  logic [2:0] q_n;

  matrix_store_writer dut (
    .clk          (clk),
    .rst          (rst),
    .start_input  (start_input),
    .dim_m        (dim_m),
    .dim_n        (dim_n),
    .elem_data    (elem_data),
    .write_en     (write_en),
    .data_ready   (data_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .commit_valid (commit_valid),
    .commit_id    (commit_id),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .busy         (busy),
    .stored_cnt   (stored_cnt),
    .q_id         (q_id),
    .q_valid      (q_valid),
    .q_m          (q_m),
    .q_n          (q_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: command phase, slot table, and the outputs expected after the next edge.
  // phase: 0 waiting for a command, 1 command announced, 2 receiving elements, 3 discarding.
  int phase;
  int cur_m, cur_n, cur_cnt;
  int wptr;
  bit vld[4];
  int sm[4];
  int sn[4];
  bit e_we, e_cv, e_ev;
  int e_addr, e_wdata, e_cid, e_ecode;

  task automatic model_reset();
    phase = 0; cur_m = 0; cur_n = 0; cur_cnt = 0; wptr = 0;
    for (int i = 0; i < 4; i++) begin
      vld[i] = 0; sm[i] = 0; sn[i] = 0;
    end
    e_we = 0; e_cv = 0; e_ev = 0;
    e_addr = 0; e_wdata = 0; e_cid = 0; e_ecode = 0;
  endtask

  task automatic model_err(input int code);
    e_ev = 1;
    e_ecode = code;
  endtask

  task automatic model_write(input int d);
    e_we = 1;
    e_addr = wptr * 25 + cur_cnt;
    e_wdata = d % 256;
    cur_cnt++;
  endtask

  task automatic model_end();
    if (phase == 3) begin
      phase = 0;
    end else begin
      if (cur_cnt == cur_m * cur_n) begin
        vld[wptr] = 1;
        sm[wptr] = cur_m;
        sn[wptr] = cur_n;
        e_cv = 1;
        e_cid = wptr;
        wptr = (wptr + 1) % 4;
      end else begin
        model_err(3);
      end
      phase = 0;
    end
  endtask

  task automatic model_step(input bit s, input int m, input int n, input int d, input bit we,
                            input bit dr);
    e_we = 0; e_cv = 0; e_ev = 0;
    case (phase)
      0: if (s) phase = 1;
      1: begin
        if (we) begin
          if (m < 1 || m > 5 || n < 1 || n > 5) begin
            model_err(1);
            phase = 3;
          end else begin
            cur_m = m; cur_n = n; cur_cnt = 0;
            vld[wptr] = 0;
            model_write(d);
            phase = 2;
          end
          if (dr) model_end();
        end else if (dr) begin
          phase = 0;
        end
      end
      2: begin
        if (s) begin
          model_err(3);
          phase = 1;
        end else begin
          if (we) begin
            if (cur_cnt < cur_m * cur_n) begin
              model_write(d);
            end else begin
              model_err(2);
              phase = 3;
            end
          end
          if (dr) model_end();
        end
      end
      default: begin
        if (s) phase = 1;
        else if (dr) phase = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    int cnt;
    int qi;
    cnt = 0;
    for (int i = 0; i < 4; i++) cnt += int'(vld[i]);
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    check("commit_valid", 32'(commit_valid), 32'(e_cv));
    check("commit_id", 32'(commit_id), 32'(e_cid));
    check("err_valid", 32'(err_valid), 32'(e_ev));
    check("err_code", 32'(err_code), 32'(e_ecode));
    check("busy", 32'(busy), 32'(phase == 2 || phase == 3));
    check("stored_cnt", 32'(stored_cnt), 32'(cnt));
    qi = $urandom_range(0, 3);
    q_id = 2'(qi);
    #1;
    check("q_valid", 32'(q_valid), 32'(vld[qi]));
    check("q_m", 32'(q_m), 32'(sm[qi]));
    check("q_n", 32'(q_n), 32'(sn[qi]));
  endtask

  // One clock cycle: drive at the falling edge, check after the following falling edge.
  task automatic cyc(input bit s, input int m, input int n, input int d, input bit we,
                     input bit dr);
    start_input = s;
    dim_m = 3'(m);
    dim_n = 3'(n);
    elem_data = 8'(d);
    write_en = we;
    data_ready = dr;
    model_step(s, m, n, d, we, dr);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    start_input = 0; dim_m = 0; dim_n = 0; elem_data = 0; write_en = 0; data_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic send(input int m, input int n, input int k, input int base, input bit dr);
    cyc(1, m, n, 0, 0, 0);
    for (int i = 0; i < k; i++) cyc(0, m, n, base + i, 1, 0);
    if (dr) cyc(0, m, n, 0, 0, 1);
  endtask

  task automatic qcheck(input string tag, input int id, input int v, input int m, input int n);
    q_id = 2'(id);
    #1;
    check({tag, "_valid"}, 32'(q_valid), 32'(v));
    if (v != 0) begin
      check({tag, "_m"}, 32'(q_m), 32'(m));
      check({tag, "_n"}, 32'(q_n), 32'(n));
    end
  endtask

  initial begin
    int rm, rn;
    bit s, we, dr;
    rst = 1;
    q_id = 0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    compare_all();
    check("reset_stored", 32'(stored_cnt), 32'd0);
    @(negedge clk);
    rst = 0;

    // 2x3 with elements 1..6.
    send(2, 3, 6, 1, 1);
    check("t1_commit_valid", 32'(commit_valid), 32'd1);
    check("t1_commit_id", 32'(commit_id), 32'd0);
    check("t1_stored", 32'(stored_cnt), 32'd1);
    qcheck("t1_q0", 0, 1, 2, 3);

    // Five 1x1 matrices: the fifth wraps onto slot 0.
    do_reset();
    for (int i = 0; i < 4; i++) send(1, 1, 1, 10 + i, 1);
    check("t2_stored_full", 32'(stored_cnt), 32'd4);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 99, 1, 0);
    check("t2_wrap_addr", 32'(mem_addr), 32'd0);
    check("t2_wrap_we", 32'(mem_we), 32'd1);
    check("t2_stored_during", 32'(stored_cnt), 32'd3);
    qcheck("t2_q0_cleared", 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 1);
    check("t2_commit_id", 32'(commit_id), 32'd0);
    check("t2_stored_after", 32'(stored_cnt), 32'd4);
    qcheck("t2_q0_set", 0, 1, 1, 1);

    // Bad dimensions; the pointer stays on slot 1.
    send(6, 2, 1, 7, 0);
    check("t3_err_valid", 32'(err_valid), 32'd1);
    check("t3_err_code", 32'(err_code), 32'd1);
    check("t3_no_we", 32'(mem_we), 32'd0);
    cyc(0, 6, 2, 0, 0, 1);
    check("t3_idle", 32'(busy), 32'd0);
    send(1, 1, 1, 3, 1);
    check("t3_next_id", 32'(commit_id), 32'd1);

    // Overflow on slot 2.
    send(2, 2, 5, 20, 0);
    check("t4_err_code", 32'(err_code), 32'd2);
    cyc(0, 2, 2, 0, 0, 1);
    check("t4_no_commit", 32'(commit_valid), 32'd0);
    qcheck("t4_q2", 2, 0, 0, 0);

    // Short command.
    send(2, 2, 3, 30, 1);
    check("t5_err_valid", 32'(err_valid), 32'd1);
    check("t5_err_code", 32'(err_code), 32'd3);

    // GEN: start then data_ready only.
    cyc(1, 3, 3, 0, 0, 0);
    cyc(0, 3, 3, 0, 0, 1);
    check("t5_gen_commit", 32'(commit_valid), 32'd0);
    check("t5_gen_err", 32'(err_valid), 32'd0);

    // Reset in the middle of a fill.
    send(2, 2, 2, 40, 0);
    do_reset();
    check("t6_stored", 32'(stored_cnt), 32'd0);
    send(1, 1, 1, 5, 1);
    check("t6_commit_id", 32'(commit_id), 32'd0);

    // Randomized command streams, including simultaneous strobes and rare resets.
    rm = 2; rn = 2;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        s  = ($urandom_range(0, 99) < 6);
        we = ($urandom_range(0, 99) < 55);
        dr = ($urandom_range(0, 99) < 10);
        if (s) begin
          if ($urandom_range(0, 9) == 0) begin
            rm = $urandom_range(0, 7);
            rn = $urandom_range(0, 7);
          end else begin
            rm = $urandom_range(1, 3);
            rn = $urandom_range(1, 2);
          end
        end
        cyc(s, rm, rn, $urandom_range(0, 255), we, dr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
